debug_uart_fifo_tx: RTL and testbench



---
 rtl/debug_uart_fifo_tx_pkg.sv | 20 ++
 rtl/debug_uart_fifo_tx_fifo.sv | 45 ++++
 rtl/debug_uart_fifo_tx.sv | 143 ++++++++++++++
 tb/tb_debug_uart_fifo_tx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_fifo_tx_pkg.sv
// debug_uart_fifo_tx_pkg: register map, status/control bit positions and shifter states
package debug_uart_fifo_tx_pkg;
  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 8;
  localparam int CT_EN    = 0;
  localparam int CT_TWO   = 1;
  localparam int CT_FLUSH = 2;
  localparam int CT_IRQEN = 3;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_STOP2} state_t;
  function automatic int reset_div(input int mhz, input int baud);
    return mhz * 1000000 / baud - 1;
  endfunction
endpackage

// File: rtl/debug_uart_fifo_tx_fifo.sv
// tinyqv_sync_fifo: single-clock FIFO with push/pop/flush and full/empty/level status
//   i_push/i_data enqueue (ignored when full), i_pop dequeues (ignored when empty),
//   i_flush empties the FIFO; o_data is the head entry, o_level counts 0..DEPTH.
module tinyqv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  assign o_full  = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/debug_uart_fifo_tx.sv
// debug_uart_fifo_tx: bus-mapped debug UART transmitter with TX FIFO, runtime divider and irq
//   addr[3:2] selects TXDATA/STATUS/DIV/CTRL; data_write_n/data_read_n != 2'b11 strobe;
//   data_out is combinational read data; uart_txd idles high; irq = irq_en && empty && idle.
module debug_uart_fifo_tx
  import debug_uart_fifo_tx_pkg::*;
#(
  parameter int CLOCK_MHZ  = 25,
  parameter int BAUD       = 1_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(reset_div(CLOCK_MHZ, BAUD));
  logic [1:0] w_sel;
  logic w_wr, w_wr_tx, w_wr_st, w_wr_div, w_wr_ctrl, w_flush;
  logic w_full, w_empty, w_pop, w_go, w_tick, w_busy, w_txd_n;
  logic [LW-1:0] w_level;
  logic [7:0] w_fdata, w_shift_n;
  logic [DIV_WIDTH-1:0] r_div, r_ldiv, r_baud, w_ldiv_n, w_baud_n;
  logic r_en, r_two, r_irq_en, r_ovf, r_ltwo, r_txd, r_irq, w_ltwo_n;
  logic [7:0] r_shift;
  logic [2:0] r_bit, w_bit_n;
  state_t r_state, w_state_n;
  logic [31:0] w_status;
  logic w_unused;
  assign w_sel      = addr[3:2];
  assign w_wr       = data_write_n != 2'b11;
  assign w_wr_tx    = w_wr && w_sel == A_TXDATA;
  assign w_wr_st    = w_wr && w_sel == A_STATUS;
  assign w_wr_div   = w_wr && w_sel == A_DIV;
  assign w_wr_ctrl  = w_wr && w_sel == A_CTRL;
  assign w_flush    = w_wr_ctrl && data_in[CT_FLUSH];
  assign w_unused   = ^{data_read_n, addr[1:0], data_in};
  assign data_ready = 1'b1;
  assign uart_txd   = r_txd;
  assign irq        = r_irq;
  tinyqv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_tx),
    .i_data  (data_in[7:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );
  assign w_busy   = r_state != S_IDLE;
  assign w_go     = r_en && !w_empty;
  assign w_tick   = r_baud == r_ldiv;
  assign w_status = {16'h0, 8'(w_level), 4'h0, r_ovf, w_empty, w_full, w_busy};
  assign data_out = w_sel == A_STATUS ? w_status :
                    w_sel == A_DIV    ? 32'(r_div) :
                    w_sel == A_CTRL   ? {28'h0, r_irq_en, 1'b0, r_two, r_en} : 32'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= RST_DIV;
      r_en     <= 1'b1;
      r_two    <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= data_in[DIV_WIDTH-1:0];
      if (w_wr_ctrl) {r_irq_en, r_two, r_en} <= {data_in[CT_IRQEN], data_in[CT_TWO], data_in[CT_EN]};
      r_ovf <= w_wr_st ? 1'b0 : (w_wr_tx && w_full) ? 1'b1 : r_ovf;
    end
  end
  // A frame ends by popping the next byte directly from its last stop bit, so
  // back-to-back frames have no idle cycle. DIV and stop mode are latched per frame.
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_baud_n  = w_tick ? '0 : r_baud + 1'b1;
    w_shift_n = r_shift;
    w_ldiv_n  = r_ldiv;
    w_ltwo_n  = r_ltwo;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n  = '0;
        w_pop     = w_go;
        w_state_n = w_go ? S_START : S_IDLE;
      end
      S_START: if (w_tick) begin
        w_state_n = S_DATA;
        w_bit_n   = 3'd0;
      end
      S_DATA: if (w_tick) begin
        w_state_n = r_bit == 3'd7 ? S_STOP : S_DATA;
        w_bit_n   = r_bit + 1'b1;
        w_shift_n = r_shift >> 1;
      end
      S_STOP: if (w_tick) begin
        w_pop     = !r_ltwo && w_go;
        w_state_n = r_ltwo ? S_STOP2 : w_go ? S_START : S_IDLE;
      end
      S_STOP2: if (w_tick) begin
        w_pop     = w_go;
        w_state_n = w_go ? S_START : S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_pop) begin
      w_shift_n = w_fdata;
      w_ldiv_n  = r_div;
      w_ltwo_n  = r_two;
    end
  end
  assign w_txd_n = w_state_n == S_DATA ? w_shift_n[0] : w_state_n != S_START;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_baud  <= '0;
      r_shift <= '0;
      r_ldiv  <= RST_DIV;
      r_ltwo  <= 1'b0;
      r_txd   <= 1'b1;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
      r_baud  <= w_baud_n;
      r_shift <= w_shift_n;
      r_ldiv  <= w_ldiv_n;
      r_ltwo  <= w_ltwo_n;
      r_txd   <= w_txd_n;
      r_irq   <= r_irq_en && w_empty && !w_busy;
    end
  end
endmodule

// File: tb/tb_debug_uart_fifo_tx.sv
// tb_debug_uart_fifo_tx: scoreboard bench decoding the serial line against queued bytes
module tb_debug_uart_fifo_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [1:0] data_write_n = 2'b11;
  logic [1:0] data_read_n = 2'b11;
  logic [31:0] data_out;
  logic data_ready, uart_txd, irq;
  typedef struct {
    logic [7:0] d;
    int p;
    bit two;
    bit gap0;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  int idle = 0;
  bit mon_en = 1'b0;
  logic [31:0] v;

  debug_uart_fifo_tx #(.CLOCK_MHZ(25), .BAUD(1_000_000), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .uart_txd(uart_txd), .irq(irq)
  );

  always #5 clk = ~clk;

  // Line monitor: frames are checked cycle by cycle against the scoreboard head.
  initial begin
    exp_t e;
    logic [10:0] fr;
    logic bad_val;
    bit ok;
    forever begin
      @(negedge clk);
      if (!mon_en) idle = 0;
      else if (uart_txd === 1'b1) idle++;
      else if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_frame: start bit seen with nothing queued");
        for (int k = 0; k < 5000 && mon_en && uart_txd !== 1'b1; k++) @(negedge clk);
        idle = 0;
      end else begin
        e = q.pop_front();
        fr = {2'b11, e.d, 1'b0};
        if (e.gap0) begin
          vectors++;
          if (idle !== 0) begin
            miscompares++;
            $display("FAIL frame_gap byte %02h: %0d idle clocks, required 0", e.d, idle);
          end
        end
        for (int i = 0; i < (e.two ? 11 : 10) && mon_en; i++) begin
          ok = 1'b1;
          bad_val = 1'b0;
          for (int c = 0; c < e.p && mon_en; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (mon_en && uart_txd !== fr[i]) begin
              ok = 1'b0;
              bad_val = uart_txd;
            end
          end
          vectors++;
          if (!ok) begin
            miscompares++;
            $display("FAIL frame_bit%0d byte %02h: line %b, required %b", i, e.d, bad_val, fr[i]);
          end
        end
        idle = 0;
        frames_done++;
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a;
    data_in = d;
    data_write_n = 2'b00;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    addr = a;
    data_read_n = 2'b00;
    #1 r = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic push_tx(input logic [7:0] d, input int p, input bit two, input bit gap0);
    exp_t e;
    e.d = d;
    e.p = p;
    e.two = two;
    e.gap0 = gap0;
    q.push_back(e);
    wr(4'h0, {24'h0, d});
  endtask

  task automatic wait_frames(input int n, input int budget, input string nm);
    for (int k = 0; k < budget && frames_done < n; k++) @(posedge clk);
    vectors++;
    if (frames_done < n) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d frames seen, required %0d", nm, frames_done, n);
    end
    @(negedge clk);
  endtask

  task automatic chk_status(input logic [31:0] want, input string nm);
    rd(4'h4, v);
    vectors++;
    if (v !== want) begin
      miscompares++;
      $display("FAIL %s: STATUS %h, required %h", nm, v, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (uart_txd !== 1'b1 || irq !== 1'b0 || data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pins: txd %b irq %b ready %b, required 1 0 1", uart_txd, irq, data_ready);
    end
    chk_status(32'h4, "reset_status");
    rd(4'h8, v);
    vectors++;
    if (v !== 32'd24) begin
      miscompares++;
      $display("FAIL reset_div: %0d, required 24", v);
    end
    rd(4'hC, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL reset_ctrl: %h, required 1", v);
    end
    rd(4'h0, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL txdata_read: %h, required 0", v);
    end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit irq_bad = 1'b0;
    push_tx(8'h55, 25, 1'b0, 1'b0);
    vectors++;
    if (uart_txd !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency0: txd %b, required 1", uart_txd);
    end
    chk_status(32'h100, "single_level1");
    @(negedge clk);
    vectors++;
    if (uart_txd !== 1'b0) begin
      miscompares++;
      $display("FAIL single_start: txd %b, required 0", uart_txd);
    end
    chk_status(32'h5, "single_busy");
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (irq !== 1'b0) irq_bad = 1'b1;
    end
    vectors++;
    if (irq_bad) begin
      miscompares++;
      $display("FAIL single_irq: irq 1 during frame, required 0");
    end
    wait_frames(1, 400, "single");
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base = frames_done;
    for (int k = 0; k < 9; k++) push_tx(8'(8'h30 + k * 8'h1D), 25, 1'b0, k != 0);
    chk_status(32'h803, "b2b_full");
    wr(4'h0, 32'hEE);
    chk_status(32'h80B, "b2b_overflow");
    wr(4'h4, 32'h0);
    chk_status(32'h803, "b2b_ovf_clear");
    wait_frames(base + 9, 9 * 260, "b2b");
    repeat (5) @(negedge clk);
  endtask

  task automatic test_div_change();
    int base = frames_done;
    push_tx(8'hA5, 25, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    wr(4'h8, 32'd3);
    push_tx(8'h3C, 4, 1'b0, 1'b1);
    rd(4'h8, v);
    vectors++;
    if (v !== 32'd3) begin
      miscompares++;
      $display("FAIL div_readback: %0d, required 3", v);
    end
    wait_frames(base + 2, 400, "div");
    repeat (5) @(negedge clk);
  endtask

  task automatic test_two_stop();
    int base = frames_done;
    wr(4'hC, 32'h3);
    push_tx(8'hFF, 4, 1'b1, 1'b0);
    push_tx(8'h00, 4, 1'b1, 1'b1);
    wait_frames(base + 2, 200, "two_stop");
    wr(4'hC, 32'h1);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_flush();
    int base = frames_done;
    push_tx(8'h11, 4, 1'b0, 1'b0);
    wr(4'h0, 32'h22);
    wr(4'h0, 32'h33);
    wr(4'h0, 32'h44);
    wr(4'hC, 32'h5);
    chk_status(32'h5, "flush_level");
    wait_frames(base + 1, 100, "flush");
    repeat (80) @(negedge clk);
    vectors++;
    if (frames_done !== base + 1) begin
      miscompares++;
      $display("FAIL flush_frames: %0d frames, required %0d", frames_done - base, 1);
    end
    chk_status(32'h4, "flush_idle");
  endtask

  task automatic test_irq_reset();
    int base = frames_done;
    wr(4'hC, 32'h9);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_idle: irq %b, required 1", irq);
    end
    push_tx(8'h5A, 4, 1'b0, 1'b0);
    push_tx(8'hC3, 4, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_busy: irq %b, required 0", irq);
    end
    for (int k = 0; k < 200 && frames_done < base + 2; k++) @(posedge clk);
    vectors++;
    if (frames_done < base + 2) begin
      miscompares++;
      $display("FAIL irq_timeout: %0d frames, required 2", frames_done - base);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early: irq %b, required 0", irq);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: irq %b, required 1", irq);
    end
    mon_en = 1'b0;
    wr(4'h0, 32'h77);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (uart_txd !== 1'b1 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: txd %b irq %b, required 1 0", uart_txd, irq);
    end
    chk_status(32'h4, "midframe_reset_status");
    rd(4'hC, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL midframe_reset_ctrl: %h, required 1", v);
    end
    rst = 1'b0;
    q.delete();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_div_change();
    test_two_stop();
    test_flush();
    test_irq_reset();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d bytes never sent, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
